// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/control stage for the 16x16 register file and
// the 8-bit ALU. Every instruction walks through a fixed four-state FSM
// (FETCH -> DECODE -> EXEC -> WB), so each one takes exactly four cycles.
//
// Ports:
//   clock        system clock; all state updates on the rising edge
//   reset        asynchronous, active-low; clears all state
//   instr_addr   ROM address (always equals pc)
//   instruction  ROM data, combinational from instr_addr
//   alu_zero     ALU zero flag, sampled on the EXEC edge for BZ
//   sel_a/sel_b  register file read selects, valid DECODE through WB
//   sel_w        register file write select, valid in WB
//   reg_wen      register file write enable, only in WB for opcodes 0x0-0x8
//   alu_op       ALU operation, valid DECODE through WB
//   wdata_sel    0 = ALU result, 1 = immediate (LDI only, in WB)
//   imm_value    immediate byte IR[7:0]
//   state        FSM state for debug (FETCH=0, DECODE=1, EXEC=2, WB=3)
//   halted       set when HALT retires; only reset clears it
//
// state  | meaning
// FETCH  | instr_addr = pc, IR captured on the edge (skipped while halted)
// DECODE | read selects and alu_op presented to the datapath
// EXEC   | ALU registers its result; branch condition captured
// WB     | register write enabled if needed; pc updated on the edge
module instr_sequencer #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] instr_addr,
    input  logic [15:0]         instruction,
    input  logic                alu_zero,
    output logic [3:0]          sel_a,
    output logic [3:0]          sel_b,
    output logic [3:0]          sel_w,
    output logic                reg_wen,
    output logic [2:0]          alu_op,
    output logic                wdata_sel,
    output logic [7:0]          imm_value,
    output logic [1:0]          state,
    output logic                halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t              fsm;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;
    logic                take_branch;

    logic [3:0]          opcode;
    logic [PC_WIDTH-1:0] target;
    logic                writes_reg;

    assign opcode     = ir[15:12];
    assign target     = PC_WIDTH'(ir[7:0]);
    // Opcodes 0x0-0x7 are ALU ops and 0x8 is LDI; nothing else writes.
    assign writes_reg = (opcode <= 4'h8);

    assign instr_addr = pc;
    assign state      = fsm;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm         <= FETCH;
            pc          <= RESET_PC;
            ir          <= 16'h0000;
            take_branch <= 1'b0;
            halted      <= 1'b0;
            sel_a       <= 4'h0;
            sel_b       <= 4'h0;
            sel_w       <= 4'h0;
            reg_wen     <= 1'b0;
            alu_op      <= 3'h0;
            wdata_sel   <= 1'b0;
            imm_value   <= 8'h00;
        end else begin
            case (fsm)
                FETCH: begin
                    // Selects are loaded straight from the ROM word so they
                    // are already valid throughout DECODE.
                    if (!halted) begin
                        ir        <= instruction;
                        sel_a     <= instruction[7:4];
                        sel_b     <= instruction[3:0];
                        alu_op    <= instruction[14:12];
                        imm_value <= instruction[7:0];
                        fsm       <= DECODE;
                    end
                end
                DECODE: begin
                    fsm <= EXEC;
                end
                EXEC: begin
                    sel_w       <= ir[11:8];
                    reg_wen     <= writes_reg;
                    wdata_sel   <= (opcode == 4'h8);
                    take_branch <= (opcode == 4'h9) ||
                                   ((opcode == 4'hA) && alu_zero);
                    fsm         <= WB;
                end
                WB: begin
                    reg_wen     <= 1'b0;
                    wdata_sel   <= 1'b0;
                    take_branch <= 1'b0;
                    if (opcode == 4'hB) begin
                        halted <= 1'b1;
                    end else if (take_branch) begin
                        pc <= target;
                    end else begin
                        pc <= pc + PC_WIDTH'(1);
                    end
                    fsm <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic        clock;
    logic        reset;
    logic [7:0]  instr_addr;
    logic [15:0] instruction;
    logic        alu_zero;
    logic [3:0]  sel_a, sel_b, sel_w;
    logic        reg_wen;
    logic [2:0]  alu_op;
    logic        wdata_sel;
    logic [7:0]  imm_value;
    logic [1:0]  state;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom [256];
    logic [7:0]  regs [16];
    logic [7:0]  alu_result;

    instr_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_addr  (instr_addr),
        .instruction (instruction),
        .alu_zero    (alu_zero),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .sel_w       (sel_w),
        .reg_wen     (reg_wen),
        .alu_op      (alu_op),
        .wdata_sel   (wdata_sel),
        .imm_value   (imm_value),
        .state       (state),
        .halted      (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Environment: combinational ROM, registered ALU, 16x8 register file.
    assign instruction = rom[instr_addr];
    assign alu_zero    = (alu_result == 8'h00);

    always @(posedge clock) begin
        if (state == 2'd2) begin
            case (alu_op)
                3'd2:    alu_result <= regs[sel_a] + regs[sel_b];
                3'd3:    alu_result <= regs[sel_a] - regs[sel_b];
                3'd4:    alu_result <= regs[sel_a] & regs[sel_b];
                3'd5:    alu_result <= regs[sel_a] | regs[sel_b];
                default: alu_result <= regs[sel_a];
            endcase
        end
    end

    always @(posedge clock) begin
        if (reg_wen) regs[sel_w] <= wdata_sel ? imm_value : alu_result;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Resets the DUT with a NOP-filled ROM and cleared datapath; leaves reset
    // deasserted on a falling edge so the next rising edge is the first fetch.
    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        alu_result = 8'h00;
        step(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rom[0] = 16'h8123;
        step(3);
        #2 reset = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (instr_addr !== 8'h00) begin errors++; $display("FAIL reset_pc got %0h want 0", instr_addr); end
        checks++; if (reg_wen !== 1'b0 || wdata_sel !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl got wen=%b wsel=%b halt=%b want 0 0 0", reg_wen, wdata_sel, halted); end
        checks++; if (sel_a !== 4'h0 || sel_b !== 4'h0 || sel_w !== 4'h0 || alu_op !== 3'h0 || imm_value !== 8'h00) begin
            errors++; $display("FAIL reset_sels got a=%h b=%h w=%h op=%h imm=%h want all 0", sel_a, sel_b, sel_w, alu_op, imm_value); end
    endtask

    task automatic test_ldi();
        do_reset();
        rom[0] = 16'h8105;
        step(1);
        checks++; if (state !== 2'd1 || reg_wen !== 1'b0) begin
            errors++; $display("FAIL ldi_decode got state=%0d wen=%b want 1 0", state, reg_wen); end
        step(2);
        checks++; if (state !== 2'd3 || reg_wen !== 1'b1 || sel_w !== 4'h1 || wdata_sel !== 1'b1 || imm_value !== 8'h05) begin
            errors++; $display("FAIL ldi_wb got state=%0d wen=%b w=%h wsel=%b imm=%h want 3 1 1 1 05",
                               state, reg_wen, sel_w, wdata_sel, imm_value); end
        step(1);
        checks++; if (instr_addr !== 8'h01 || state !== 2'd0 || reg_wen !== 1'b0) begin
            errors++; $display("FAIL ldi_after got pc=%h state=%0d wen=%b want 01 0 0", instr_addr, state, reg_wen); end
        checks++; if (regs[1] !== 8'h05) begin errors++; $display("FAIL ldi_reg got %h want 05", regs[1]); end
    endtask

    task automatic test_alu_add();
        do_reset();
        rom[0] = 16'h8103;
        rom[1] = 16'h8204;
        rom[2] = 16'h2312;
        step(11);
        checks++; if (sel_a !== 4'h1 || sel_b !== 4'h2 || alu_op !== 3'd2 || sel_w !== 4'h3 || reg_wen !== 1'b1 || wdata_sel !== 1'b0) begin
            errors++; $display("FAIL add_wb got a=%h b=%h op=%0d w=%h wen=%b wsel=%b want 1 2 2 3 1 0",
                               sel_a, sel_b, alu_op, sel_w, reg_wen, wdata_sel); end
        step(1);
        checks++; if (regs[3] !== 8'h07) begin errors++; $display("FAIL add_reg got %h want 07", regs[3]); end
        checks++; if (instr_addr !== 8'h03) begin errors++; $display("FAIL add_pc got %h want 03", instr_addr); end
    endtask

    task automatic test_branch(input logic [15:0] sub_word, input logic [7:0] exp_pc);
        do_reset();
        rom[0] = 16'h8101;
        rom[1] = sub_word;
        rom[2] = 16'hA010;
        step(11);
        checks++; if (state !== 2'd3 || reg_wen !== 1'b0) begin
            errors++; $display("FAIL bz_wb got state=%0d wen=%b want 3 0", state, reg_wen); end
        step(1);
        checks++; if (instr_addr !== exp_pc) begin
            errors++; $display("FAIL bz_pc(%h) got %h want %h", sub_word, instr_addr, exp_pc); end
    endtask

    task automatic test_jmp_wrap();
        do_reset();
        rom[0]   = 16'h90FF;
        rom[255] = 16'hC000;
        step(4);
        checks++; if (instr_addr !== 8'hFF) begin errors++; $display("FAIL jmp_pc got %h want ff", instr_addr); end
        step(3);
        checks++; if (reg_wen !== 1'b0) begin errors++; $display("FAIL nop_wen got %b want 0", reg_wen); end
        step(1);
        checks++; if (instr_addr !== 8'h00) begin errors++; $display("FAIL wrap_pc got %h want 00", instr_addr); end
    endtask

    task automatic test_halt();
        do_reset();
        rom[0] = 16'hB000;
        step(4);
        checks++; if (halted !== 1'b1 || instr_addr !== 8'h00 || state !== 2'd0) begin
            errors++; $display("FAIL halt_retire got halt=%b pc=%h state=%0d want 1 00 0", halted, instr_addr, state); end
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++; if (reg_wen !== 1'b0 || state !== 2'd0 || instr_addr !== 8'h00) begin
                errors++; $display("FAIL halt_park[%0d] got wen=%b state=%0d pc=%h want 0 0 00", i, reg_wen, state, instr_addr); end
        end
        #2 reset = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %b want 0", halted); end
    endtask

    task automatic test_reset_mid_wb();
        do_reset();
        rom[0] = 16'h8105;
        step(3);
        checks++; if (state !== 2'd3 || reg_wen !== 1'b1) begin
            errors++; $display("FAIL midwb_pre got state=%0d wen=%b want 3 1", state, reg_wen); end
        #2 reset = 1'b0;
        #1;
        checks++; if (state !== 2'd0 || instr_addr !== 8'h00 || reg_wen !== 1'b0) begin
            errors++; $display("FAIL midwb_async got state=%0d pc=%h wen=%b want 0 00 0", state, instr_addr, reg_wen); end
        step(1);
        checks++; if (regs[1] !== 8'h00) begin errors++; $display("FAIL midwb_nowrite got %h want 00", regs[1]); end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_ldi();
        test_alu_add();
        test_branch(16'h3211, 8'h10);
        test_branch(16'h3212, 8'h03);
        test_jmp_wrap();
        test_halt();
        test_reset_mid_wb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
